// File: rtl/range_burst_arbiter.sv
// range_burst_arbiter: round-robin burst arbiter that shares one
// min/max range-finder between two requesters.
module range_burst_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       valid,
  input  logic [1:0]       last,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic [1:0]       accept,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             rf_go,
  output logic             rf_finish,
  output logic [WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t state;

  logic [7:0] count;
  logic [7:0] idle_cnt;
  logic       owner;
  logic       prio;
  logic       started;
  logic       fault;

  logic             own_req;
  logic             own_valid;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic             take;
  logic             at_cap;
  logic [1:0]       elig;
  logic             pick;

  assign own_req   = req[owner];
  assign own_valid = valid[owner];
  assign own_last  = last[owner];
  assign own_data  = owner ? data1 : data0;

  // error and abort win over a sample presented in the same cycle
  assign take   = (state == STREAM) && !rf_error
                  && own_req && own_valid;
  assign accept = take ? gnt : 2'b00;
  assign at_cap = (count + 8'd1) == 8'(MAX_LEN);

  // a requester still holding req in its own done cycle is not re-granted
  assign elig = req & ~done;
  assign pick = (&elig) ? prio : elig[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      done      <= 2'b00;
      result    <= '0;
      err       <= 1'b0;
      rf_go     <= 1'b0;
      rf_finish <= 1'b0;
      rf_data   <= '0;
      count     <= '0;
      idle_cnt  <= '0;
      owner     <= 1'b0;
      prio      <= 1'b0;
      started   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      rf_go     <= 1'b0;
      rf_finish <= 1'b0;
      done      <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            owner    <= pick;
            gnt      <= pick ? 2'b10 : 2'b01;
            count    <= '0;
            idle_cnt <= '0;
            started  <= 1'b0;
            fault    <= 1'b0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (rf_error) begin
            fault <= 1'b1;
            state <= DONE;
          end else if (!own_req) begin
            fault <= 1'b1;
            state <= FLUSH;
          end else if (own_valid) begin
            rf_data  <= own_data;
            idle_cnt <= '0;
            count    <= count + 8'd1;
            started  <= 1'b1;
            rf_go    <= !started;
            if (own_last || at_cap) begin
              // go and finish must never share a cycle
              if (started) begin
                rf_finish <= 1'b1;
                state     <= DONE;
              end else begin
                state <= FLUSH;
              end
            end
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
            if ((idle_cnt + 8'd1) == 8'(TIMEOUT)) begin
              fault <= 1'b1;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (rf_error) begin
            fault <= 1'b1;
          end else begin
            rf_finish <= started;
          end
          state <= DONE;
        end
        DONE: begin
          result <= rf_finish ? rf_range : '0;
          err    <= fault;
          done   <= gnt;
          gnt    <= 2'b00;
          prio   <= ~owner;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_burst_arbiter.sv
// tb_range_burst_arbiter: directed and random bursts checked against
// a max-minus-min burst model with an emulated range-finder.
module tb_range_burst_arbiter;

  localparam int W    = 8;
  localparam int MAXL = 4;
  localparam int TMO  = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req   = 2'b00;
  logic [1:0]   valid = 2'b00;
  logic [1:0]   last  = 2'b00;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic [1:0]   gnt, accept, done;
  logic [W-1:0] result, rf_data, rf_range;
  logic         err, rf_go, rf_finish;
  logic         rf_error = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_tot = 0;
  int fin_tot = 0;
  int both_tot = 0;
  logic [W-1:0] go_val = '0;
  logic [W-1:0] fin_val = '0;

  always #5 clock = ~clock;

  range_burst_arbiter #(
    .WIDTH(W), .MAX_LEN(MAXL), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .valid(valid), .last(last),
    .data0(data0), .data1(data1),
    .gnt(gnt), .accept(accept), .done(done),
    .result(result), .err(err),
    .rf_go(rf_go), .rf_finish(rf_finish),
    .rf_data(rf_data), .rf_range(rf_range),
    .rf_error(rf_error)
  );

  // emulated min/max datapath
  logic [W-1:0] dmin = '0;
  logic [W-1:0] dmax = '0;
  logic         drun = 1'b0;
  logic [W-1:0] lo, hi;

  always_comb begin
    lo = (dmin < rf_data) ? dmin : rf_data;
    hi = (dmax > rf_data) ? dmax : rf_data;
  end
  assign rf_range = drun ? (hi - lo) : '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      drun <= 1'b0;
    end else if (rf_go) begin
      drun <= 1'b1;
      dmin <= rf_data;
      dmax <= rf_data;
    end else if (rf_finish) begin
      drun <= 1'b0;
    end else if (drun) begin
      dmin <= lo;
      dmax <= hi;
    end
  end

  always @(negedge clock) begin
    if (rf_go) begin
      go_tot <= go_tot + 1;
      go_val <= rf_data;
    end
    if (rf_finish) begin
      fin_tot <= fin_tot + 1;
      fin_val <= rf_data;
    end
    if (rf_go && rf_finish) both_tot <= both_tot + 1;
  end

  function automatic logic [1:0] oh(input int who);
    return (who != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input int who, input bit v, input bit l,
                       input logic [W-1:0] d);
    logic [W-1:0] junk;
    junk = W'($urandom);
    valid[who]     = v;
    last[who]      = l;
    valid[1 - who] = 1'($urandom);
    last[1 - who]  = 1'($urandom);
    if (who == 0) begin
      data0 = d;
      data1 = junk;
    end else begin
      data1 = d;
      data0 = junk;
    end
  endtask

  task automatic grant(input int who, output int cg);
    int gw;
    gw = 0;
    req[who] = 1'b1;
    while (gw < 8 && !gnt[who]) begin
      tick();
      gw++;
    end
    check($sformatf("gnt%0d_latency", who), gw, 1);
    check($sformatf("gnt%0d_onehot", who), gnt, oh(who));
    cg = cyc;
  endtask

  task automatic send(input int who, input logic [W-1:0] d,
                      input bit l, input bit exp_acc);
    drive(who, 1'b1, l, d);
    #1;
    check("accept", accept, exp_acc ? oh(who) : 2'b00);
    check("gnt_held", gnt, oh(who));
    tick();
  endtask

  task automatic idle_step(input int who, input bit chk,
                           input logic [W-1:0] hold);
    drive(who, 1'b0, 1'b0, '0);
    #1;
    check("gap_accept", accept, 2'b00);
    if (chk) check("hold_data", rf_data, hold);
    tick();
  endtask

  task automatic finish(input int who, input int g0, input int f0,
                        input int exp_res, input bit exp_err,
                        input int exp_go, input int exp_fin,
                        input logic [W-1:0] go_d,
                        input logic [W-1:0] fin_d, output int cd);
    int n;
    n = 0;
    valid = 2'b00;
    last  = 2'b00;
    while (n < 16 && !done[who]) begin
      tick();
      n++;
    end
    check($sformatf("done%0d_seen", who), done, oh(who));
    check("result", result, exp_res);
    check("err", err, exp_err);
    check("gnt_cleared", gnt, 2'b00);
    check("go_count", go_tot - g0, exp_go);
    check("finish_count", fin_tot - f0, exp_fin);
    check("go_finish_overlap", both_tot, 0);
    if (exp_go > 0) check("go_data", go_val, go_d);
    if (exp_fin > 0) check("finish_data", fin_val, fin_d);
    req[who] = 1'b0;
    cd = cyc;
  endtask

  task automatic run(input int who, input logic [W-1:0] s[$],
                     input bit with_last, input int gapmax,
                     output int gcyc);
    int n, acc, cg, cl, cd, g0, f0, gap;
    logic [W-1:0] mx, mn;
    n   = s.size();
    acc = (with_last && n <= MAXL) ? n : MAXL;
    mx  = s[0];
    mn  = s[0];
    for (int i = 1; i < acc; i++) begin
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    g0 = go_tot;
    f0 = fin_tot;
    grant(who, cg);
    cl = cg;
    for (int i = 0; i < n && i <= MAXL; i++) begin
      if (i < MAXL) begin
        gap = $urandom_range(gapmax, 0);
        for (int k = 0; k < gap; k++)
          idle_step(who, i > 0, (i > 0) ? s[i - 1] : '0);
      end
      if (i < acc) cl = cyc;
      send(who, s[i], with_last && (i == n - 1), i < acc);
    end
    finish(who, g0, f0, int'(mx - mn), 1'b0, 1, 1,
           s[0], s[acc - 1], cd);
    check("done_latency", cd - cl, (acc > 1) ? 2 : 3);
    gcyc = cd - cg;
  endtask

  initial begin
    logic [W-1:0] q[$];
    int gc, cg, cd, cl, g0, f0, who, n;
    bit wl;

    repeat (3) tick();
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_go", rf_go, 1'b0);
    check("rst_finish", rf_finish, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, 0);
    check("rst_rf_data", rf_data, 0);
    reset = 1'b0;
    #1;
    check("rst_accept", accept, 2'b00);
    tick();

    q = '{8'd10, 8'd40, 8'd5, 8'd20};
    run(0, q, 1'b1, 0, gc);
    check("t1_result", result, 35);
    check("t1_gnt_cycles", gc, 5);
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req[1] = 1'b1;
    q = '{8'd4, 8'd9};
    run(0, q, 1'b1, 0, gc);
    q = '{8'd100, 8'd30, 8'd70};
    run(1, q, 1'b1, 0, gc);
    tick();
    req[1] = 1'b1;
    q = '{8'd6, 8'd2};
    run(0, q, 1'b1, 0, gc);
    req[1] = 1'b0;
    tick();

    q = '{8'd77};
    run(0, q, 1'b1, 0, gc);
    check("single_go", go_val, 77);
    tick();

    g0 = go_tot;
    f0 = fin_tot;
    grant(0, cg);
    send(0, 8'd3, 1'b0, 1'b1);
    idle_step(0, 1'b1, 8'd3);
    idle_step(0, 1'b1, 8'd3);
    cl = cyc;
    send(0, 8'd9, 1'b0, 1'b1);
    finish(0, g0, f0, 6, 1'b1, 1, 1, 8'd3, 8'd9, cd);
    check("timeout_latency", cd - cl, TMO + 3);
    tick();

    q = '{8'd1, 8'd2, 8'd3, 8'd8, 8'd50};
    run(1, q, 1'b0, 0, gc);
    check("cap_result", result, 7);
    tick();

    g0 = go_tot;
    f0 = fin_tot;
    grant(1, cg);
    send(1, 8'd5, 1'b0, 1'b1);
    send(1, 8'd12, 1'b0, 1'b1);
    req[1] = 1'b0;
    finish(1, g0, f0, 7, 1'b1, 1, 1, 8'd5, 8'd12, cd);
    tick();

    grant(0, cg);
    send(0, 8'd7, 1'b0, 1'b1);
    send(0, 8'd9, 1'b0, 1'b1);
    reset = 1'b1;
    req   = 2'b00;
    valid = 2'b00;
    tick();
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_go", rf_go, 1'b0);
    check("mid_rst_finish", rf_finish, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_result", result, 0);
    check("mid_rst_rf_data", rf_data, 0);
    check("mid_rst_accept", accept, 2'b00);
    reset = 1'b0;
    tick();

    g0 = go_tot;
    f0 = fin_tot;
    grant(0, cg);
    send(0, 8'd4, 1'b0, 1'b1);
    send(0, 8'd60, 1'b0, 1'b1);
    valid    = 2'b00;
    rf_error = 1'b1;
    tick();
    rf_error = 1'b0;
    finish(0, g0, f0, 0, 1'b1, 1, 0, 8'd4, 8'd0, cd);
    tick();

    for (int b = 0; b < 14; b++) begin
      who = $urandom_range(1, 0);
      n   = $urandom_range(6, 1);
      wl  = (n < MAXL) ? 1'b1 : 1'($urandom);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(W'($urandom));
      run(who, q, wl, TMO - 2, gc);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
